// File: rtl/sr_tail_checker_pkg.sv
// Shared definitions for the shift-register tail checker and its writer-side
// pattern generator: state encoding, default sync byte and payload stepping.
package sr_tail_checker_pkg;

  localparam int BYTE_W = 8;

  // Byte that marks the start of the incrementing-counter test payload.
  localparam logic [BYTE_W-1:0] DEF_SYNC_BYTE = 8'hA5;

  // Checker state encoding; value 3 is never entered.
  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  // Next payload byte after b; wraps 0xFF -> 0x00 so both ends agree.
  function automatic logic [BYTE_W-1:0] next_byte(input logic [BYTE_W-1:0] b);
    return b + 8'd1;
  endfunction

endpackage

// File: rtl/sr_tail_checker_if.sv
// Byte stream seen at the tail of the delay chain: shift strobe, tail byte and
// the writer's injection strobe.
interface sr_tail_checker_if;
  import sr_tail_checker_pkg::*;

  logic              shift_enable;
  logic [BYTE_W-1:0] data_in;
  logic              start;

  modport master (output shift_enable, output data_in, output start);
  modport slave  (input  shift_enable, input  data_in, input  start);

endinterface

// File: rtl/sr_lat_timer.sv
// Chain latency timer: armed by the writer's start strobe, counts raw clock
// cycles (saturating) and captures the elapsed count when sync is found.
module sr_lat_timer #(
  parameter int LAT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic             capture,
  output logic [LAT_W-1:0] latency,
  output logic             latency_valid
);

  localparam logic [LAT_W-1:0] SAT = '1;

  logic             armed;
  logic [LAT_W-1:0] timer;
  logic [LAT_W-1:0] elapsed;

  // Cycles elapsed including the current edge, pinned at all-ones.
  assign elapsed = (timer == SAT) ? SAT : timer + LAT_W'(1);

  // Arm/restart on start, count while armed, capture and disarm on sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed         <= 1'b0;
      timer         <= '0;
      latency       <= '0;
      latency_valid <= 1'b0;
    end else if (clear) begin
      armed         <= 1'b0;
      timer         <= '0;
      latency       <= '0;
      latency_valid <= 1'b0;
    end else if (start) begin
      timer <= '0;
      if (capture) begin
        latency       <= '0;
        latency_valid <= 1'b1;
        armed         <= 1'b0;
      end else begin
        latency_valid <= 1'b0;
        armed         <= 1'b1;
      end
    end else if (armed) begin
      if (capture) begin
        latency       <= elapsed;
        latency_valid <= 1'b1;
        armed         <= 1'b0;
      end else begin
        timer <= elapsed;
      end
    end
  end

endmodule

// File: rtl/sr_tail_checker.sv
// Tail-of-chain self-check: hunts for the sync byte, verifies the incrementing
// payload, tracks lock, counts errors and measures chain latency.
module sr_tail_checker
  import sr_tail_checker_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter int                LOCK_COUNT  = 4,
  parameter int                UNLOCK_ERRS = 3,
  parameter int                ERR_W       = 8,
  parameter int                LAT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_tail_checker_if.slave   tail,
  input  logic               clear,
  output logic               locked,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [LAT_W-1:0]   latency,
  output logic               latency_valid,
  output logic [1:0]         state
);

  localparam logic [3:0]       LOCK_CNT   = 4'(LOCK_COUNT);
  localparam logic [3:0]       UNLOCK_CNT = 4'(UNLOCK_ERRS);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] exp_q, exp_d;
  logic [3:0]        good_q, good_d;
  logic [3:0]        bad_q, bad_d;
  logic [ERR_W-1:0]  err_d;
  logic [3:0]        good_inc, bad_inc;
  logic              is_match, is_sync, hunt_sync;

  assign good_inc = good_q + 4'd1;
  assign bad_inc  = bad_q + 4'd1;
  assign is_match = (tail.data_in == exp_q);
  assign is_sync  = (tail.data_in == SYNC_BYTE);
  assign state    = state_q;

  // Next-state and counter updates; only enabled shifts carry a valid byte.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    good_d    = good_q;
    bad_d     = bad_q;
    err_d     = err_cnt;
    hunt_sync = 1'b0;
    if (tail.shift_enable) begin
      case (state_q)
        ST_HUNT: begin
          if (is_sync) begin
            state_d   = ST_ACQ;
            exp_d     = '0;
            good_d    = '0;
            hunt_sync = 1'b1;
          end
        end
        ST_ACQ: begin
          if (is_match) begin
            good_d = good_inc;
            exp_d  = next_byte(exp_q);
            if (good_inc == LOCK_CNT) begin
              state_d = ST_LOCK;
              bad_d   = '0;
            end
          end else if (is_sync) begin
            exp_d  = '0;
            good_d = '0;
          end else begin
            state_d = ST_HUNT;
            good_d  = '0;
          end
        end
        ST_LOCK: begin
          exp_d = next_byte(exp_q);
          if (is_match) begin
            bad_d = '0;
          end else begin
            if (err_cnt != ERR_MAX) err_d = err_cnt + ERR_W'(1);
            bad_d = bad_inc;
            if (bad_inc == UNLOCK_CNT) begin
              state_d = ST_HUNT;
              good_d  = '0;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // State, payload tracking and error registers with reset/clear priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      exp_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      err_cnt <= '0;
      locked  <= 1'b0;
    end else if (clear) begin
      state_q <= ST_HUNT;
      exp_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      err_cnt <= '0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      err_cnt <= err_d;
      locked  <= (state_d == ST_LOCK);
    end
  end

  sr_lat_timer #(.LAT_W(LAT_W)) u_lat_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .start         (tail.start),
    .capture       (hunt_sync),
    .latency       (latency),
    .latency_valid (latency_valid)
  );

endmodule

// File: tb/tb_sr_tail_checker.sv
// Bench for sr_tail_checker: a 5-stage byte delay chain feeds two checkers
// (8-bit and 2-bit error counters); expectations are queued when a byte is
// injected and compared once that byte has reached the checker.
module tb_sr_tail_checker;
  import sr_tail_checker_pkg::*;

  localparam int LAT_W = 16;
  localparam int DEPTH = 5;

  localparam int S_STATE   = 0;
  localparam int S_LOCKED  = 1;
  localparam int S_ERR     = 2;
  localparam int S_LAT     = 3;
  localparam int S_VALID   = 4;
  localparam int S_ERR2    = 5;
  localparam int S_LOCKED2 = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
    int          due;
  } exp_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic [7:0]       head  = 8'h00;
  logic [7:0]       chain [0:DEPTH-1] = '{default: 8'h00};

  logic             locked, locked2, latency_valid, latency_valid2;
  logic [7:0]       err_cnt;
  logic [1:0]       err_cnt2;
  logic [LAT_W-1:0] latency, latency2;
  logic [1:0]       state, state2;

  exp_t       sb[$];
  int         shift_cnt = 0;
  int         n_checks  = 0;
  int         n_fail    = 0;
  bit         gap_mode  = 1'b0;
  logic [7:0] pay       = 8'h00;

  sr_tail_checker_if bus ();

  sr_tail_checker #(.ERR_W(8), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .tail(bus), .clear(clear), .locked(locked),
    .err_cnt(err_cnt), .latency(latency), .latency_valid(latency_valid), .state(state)
  );

  sr_tail_checker #(.ERR_W(2), .LAT_W(LAT_W)) dut2 (
    .clk(clk), .rst_n(rst_n), .tail(bus), .clear(clear), .locked(locked2),
    .err_cnt(err_cnt2), .latency(latency2), .latency_valid(latency_valid2), .state(state2)
  );

  always #5 clk = ~clk;

  // Delay chain model: advances only on enabled shifts.
  always @(posedge clk) begin
    if (bus.shift_enable) begin
      chain[0] <= head;
      for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
    end
  end

  assign bus.data_in = chain[DEPTH-1];

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_STATE:   return 32'(state);
      S_LOCKED:  return 32'(locked);
      S_ERR:     return 32'(err_cnt);
      S_LAT:     return 32'(latency);
      S_VALID:   return 32'(latency_valid);
      S_ERR2:    return 32'(err_cnt2);
      S_LOCKED2: return 32'(locked2);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue an expectation for the byte most recently injected at the head.
  task automatic expect_sb(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    e.due = shift_cnt + DEPTH;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= shift_cnt) begin
      e = sb.pop_front();
      check_output(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input logic st, input logic en, input logic clr);
    @(negedge clk);
    head             = b;
    bus.start        = st;
    bus.shift_enable = en;
    clear            = clr;
    @(posedge clk);
    #1;
    if (en) shift_cnt++;
    bus.start        = 1'b0;
    bus.shift_enable = 1'b0;
    clear            = 1'b0;
    drain();
  endtask

  task automatic send(input logic [7:0] b, input logic st);
    apply_stimulus(b, st, 1'b1, 1'b0);
    if (gap_mode) apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_sync(input logic st);
    send(DEF_SYNC_BYTE, st);
    pay = 8'h00;
  endtask

  task automatic send_pay(input logic corrupt);
    send(corrupt ? (pay ^ 8'h80) : pay, 1'b0);
    pay = next_byte(pay);
  endtask

  task automatic flush();
    repeat (DEPTH + 1) send_pay(1'b0);
  endtask

  initial begin
    bus.shift_enable = 1'b0;
    bus.start        = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_state", 32'(state), 32'd0);
    check_output("rst_locked", 32'(locked), 32'd0);
    check_output("rst_err", 32'(err_cnt), 32'd0);
    check_output("rst_lat", 32'(latency), 32'd0);
    check_output("rst_valid", 32'(latency_valid), 32'd0);
    rst_n = 1'b1;

    // Nominal lock with latency measurement
    send_sync(1'b1);
    expect_sb("nom_acq_state", S_STATE, 32'd1);
    expect_sb("nom_latency", S_LAT, 32'd5);
    expect_sb("nom_lat_valid", S_VALID, 32'd1);
    repeat (3) send_pay(1'b0);
    expect_sb("nom_not_locked", S_LOCKED, 32'd0);
    send_pay(1'b0);
    expect_sb("nom_locked", S_LOCKED, 32'd1);
    expect_sb("nom_lock_state", S_STATE, 32'd2);
    expect_sb("nom_err", S_ERR, 32'd0);

    // Payload wrap FF -> 00
    repeat (252) send_pay(1'b0);
    expect_sb("wrap_ff_locked", S_LOCKED, 32'd1);
    repeat (6) send_pay(1'b0);
    expect_sb("wrap_locked", S_LOCKED, 32'd1);
    expect_sb("wrap_err", S_ERR, 32'd0);

    // Isolated then consecutive errors while locked
    send_pay(1'b1);
    send_pay(1'b0);
    send_pay(1'b0);
    send_pay(1'b1);
    send_pay(1'b0);
    expect_sb("iso_err", S_ERR, 32'd2);
    expect_sb("iso_locked", S_LOCKED, 32'd1);
    send_pay(1'b1);
    expect_sb("burst1_state", S_STATE, 32'd2);
    send_pay(1'b1);
    expect_sb("burst2_err", S_ERR, 32'd4);
    expect_sb("burst2_state", S_STATE, 32'd2);
    send_pay(1'b1);
    expect_sb("burst3_err", S_ERR, 32'd5);
    expect_sb("burst3_state", S_STATE, 32'd0);
    expect_sb("burst3_locked", S_LOCKED, 32'd0);
    expect_sb("burst3_err2_sat", S_ERR2, 32'd3);

    // Relock without start keeps the earlier latency
    send_sync(1'b0);
    repeat (4) send_pay(1'b0);
    expect_sb("relock_locked", S_LOCKED, 32'd1);
    expect_sb("relock_latency", S_LAT, 32'd5);
    expect_sb("relock_valid", S_VALID, 32'd1);
    flush();

    // Clear while locked
    apply_stimulus(pay, 1'b0, 1'b1, 1'b1);
    pay = next_byte(pay);
    check_output("clr_state", 32'(state), 32'd0);
    check_output("clr_locked", 32'(locked), 32'd0);
    check_output("clr_err", 32'(err_cnt), 32'd0);
    check_output("clr_err2", 32'(err_cnt2), 32'd0);
    check_output("clr_lat", 32'(latency), 32'd0);
    check_output("clr_valid", 32'(latency_valid), 32'd0);

    // Acquire failure, then re-sync from within ACQUIRE
    send_sync(1'b0);
    send_pay(1'b0);
    send_pay(1'b0);
    expect_sb("acq_state", S_STATE, 32'd1);
    send(8'h7E, 1'b0);
    expect_sb("acqfail_state", S_STATE, 32'd0);
    expect_sb("acqfail_err", S_ERR, 32'd0);
    send_sync(1'b0);
    send_pay(1'b0);
    send_sync(1'b0);
    expect_sb("resync_state", S_STATE, 32'd1);
    repeat (4) send_pay(1'b0);
    expect_sb("resync_locked", S_LOCKED, 32'd1);
    expect_sb("resync_lock_state", S_STATE, 32'd2);
    expect_sb("resync_no_latency", S_VALID, 32'd0);

    // Error counter saturation on the 2-bit instance
    for (int k = 1; k <= 5; k++) begin
      send_pay(1'b1);
      expect_sb($sformatf("sat_err2_%0d", k), S_ERR2, (k > 3) ? 32'd3 : 32'(k));
      send_pay(1'b0);
    end
    expect_sb("sat_err", S_ERR, 32'd5);
    expect_sb("sat_locked", S_LOCKED, 32'd1);
    expect_sb("sat_locked2", S_LOCKED2, 32'd1);
    flush();
    apply_stimulus(pay, 1'b0, 1'b1, 1'b1);
    pay = next_byte(pay);
    check_output("clr2_err", 32'(err_cnt), 32'd0);

    // Shift enable on alternate cycles
    gap_mode = 1'b1;
    send_sync(1'b1);
    expect_sb("gap_latency", S_LAT, 32'd10);
    expect_sb("gap_valid", S_VALID, 32'd1);
    repeat (4) send_pay(1'b0);
    expect_sb("gap_locked", S_LOCKED, 32'd1);
    repeat (4) send_pay(1'b0);
    expect_sb("gap_hold_locked", S_LOCKED, 32'd1);
    expect_sb("gap_err", S_ERR, 32'd0);
    flush();
    gap_mode = 1'b0;

    // Asynchronous reset mid-stream, then relock
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_state", 32'(state), 32'd0);
    check_output("arst_locked", 32'(locked), 32'd0);
    check_output("arst_lat", 32'(latency), 32'd0);
    check_output("arst_valid", 32'(latency_valid), 32'd0);
    send_pay(1'b0);
    send_pay(1'b0);
    rst_n = 1'b1;
    send_sync(1'b0);
    repeat (4) send_pay(1'b0);
    expect_sb("post_rst_locked", S_LOCKED, 32'd1);
    expect_sb("post_rst_valid", S_VALID, 32'd0);
    flush();

    check_output("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
